// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the FIFO-draining UART transmitter.
// Optional macro PARITY_EN adds an even-parity bit between the data bits and the stop bit.
package uart_tx_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
`ifdef PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd5
  } state_t;

  // Clock cycles between consecutive fifo_rd pulses while the FIFO stays non-empty.
  function automatic int frame_period(input int cpb, input int dw);
`ifdef PARITY_EN
    return (3 + dw) * cpb + 2;
`else
    return (2 + dw) * cpb + 2;
`endif
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, pulses o_bit_tick on the wrap cycle.
// o_pre_tick fires one cycle earlier so callers can register outputs that must align with the wrap.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clear,
  output logic o_bit_tick,
  output logic o_pre_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (r_cnt == LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_bit_tick = i_en && (r_cnt == LAST);
  assign o_pre_tick = i_en && (r_cnt == PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains an 8-bit FIFO one byte at a time and serialises each byte as a UART frame (8N1 by default).
// Define PARITY_EN to append an even-parity bit before the stop bit.
module fifo_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = UART_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_t            r_state, w_state_next;
  logic [DATA_W-1:0] r_shift, w_shift_next;
  logic [IDX_W-1:0]  r_bit_idx, w_bit_idx_next;
  logic              r_tx, w_tx_next;
  logic              r_busy;
  logic              r_tx_done;
  logic              w_rd;
  logic              w_baud_en;
  logic              w_bit_tick;
  logic              w_pre_tick;
`ifdef PARITY_EN
  logic              r_parity, w_parity_next;
`endif

  assign w_baud_en = (r_state != IDLE) && (r_state != FETCH);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (w_baud_en),
    .i_clear   (!w_baud_en),
    .o_bit_tick(w_bit_tick),
    .o_pre_tick(w_pre_tick)
  );

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    w_rd           = 1'b0;
`ifdef PARITY_EN
    w_parity_next  = r_parity;
`endif
    case (r_state)
      IDLE: begin
        if (!fifo_empty) begin
          w_rd         = 1'b1;
          w_state_next = FETCH;
        end
      end
      FETCH: begin
        w_shift_next  = fifo_data;
`ifdef PARITY_EN
        w_parity_next = ^fifo_data;
`endif
        w_state_next  = START;
      end
      START: begin
        if (w_bit_tick) begin
          w_bit_idx_next = '0;
          w_state_next   = DATA;
        end
      end
      DATA: begin
        if (w_bit_tick) begin
          if (r_bit_idx == LAST_IDX) begin
`ifdef PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
            w_shift_next   = r_shift >> 1;
          end
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (w_bit_tick) begin
          w_state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (w_bit_tick) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase

    // tx is registered, so its value is derived from the state being entered.
    w_tx_next = 1'b1;
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
`ifdef PARITY_EN
      PARITY:  w_tx_next = r_parity;
`endif
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      r_tx      <= w_tx_next;
      r_busy    <= (w_state_next != IDLE);
      r_tx_done <= (r_state == STOP) && w_pre_tick;
    end
  end

`ifdef PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= w_parity_next;
    end
  end
`endif

  // Gated by rst_n so the FIFO is never popped while the transmitter is held in reset.
  assign fifo_rd = w_rd & rst_n;
  assign tx      = r_tx;
  assign busy    = r_busy;
  assign tx_done = r_tx_done;

endmodule
